// File: rtl/lc3b_types.sv
// Shared LC-3b types for the memory stage: word type, controller states and
// byte-enable encodings.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE,
        IND,
        ACCESS,
        DONE
    } lc3b_mem_state;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    // dmem is word-addressed on the bus; byte selection happens through the enables.
    function automatic lc3b_word word_addr(input lc3b_word a);
        return a & 16'hfffe;
    endfunction

endpackage

// File: rtl/mem_store_align.sv
// Store lane steering: replicates the byte for byte stores and picks the lane
// enable from the address LSB.
module mem_store_align
    import lc3b_types::*;
(
    input  logic       addr0,
    input  logic       byte_op,
    input  lc3b_word   store_data,
    output lc3b_word   wdata,
    output logic [1:0] byte_enable
);

    always_comb begin
        if (byte_op) begin
            wdata       = {store_data[7:0], store_data[7:0]};
            byte_enable = addr0 ? BE_HI : BE_LO;
        end else begin
            wdata       = store_data;
            byte_enable = BE_WORD;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3b memory-stage controller: turns EX/MEM load/store ops into handshaked
// dmem transactions, sequences indirect ops and stalls the pipeline until done.
module mem_access_ctrl
    import lc3b_types::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_byte,
    input  logic             mem_indirect,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    input  logic             dmem_resp,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] dmem_address,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [1:0]       dmem_byte_enable,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             stall,
    output logic [WIDTH-1:0] mdr_out,
    output logic [WIDTH-1:0] mar_out
);

    lc3b_mem_state state;
    lc3b_word      addr_q;
    lc3b_word      sd_q;
    logic          write_q;
    logic          byte_q;

    logic          memop;
    logic          align_addr0;
    logic          align_byte;
    lc3b_word      align_sd;
    lc3b_word      align_wdata;
    logic [1:0]    align_be;

    assign memop = valid_in & (mem_read | mem_write);

    // In IDLE the request is built from the incoming op; leaving IND it is built
    // from the pointer just read and the latched store data.
    always_comb begin
        if (state == IDLE) begin
            align_addr0 = addr[0];
            align_byte  = mem_byte;
            align_sd    = store_data;
        end else begin
            align_addr0 = dmem_rdata[0];
            align_byte  = byte_q;
            align_sd    = sd_q;
        end
    end

    mem_store_align u_align (
        .addr0       (align_addr0),
        .byte_op     (align_byte),
        .store_data  (align_sd),
        .wdata       (align_wdata),
        .byte_enable (align_be)
    );

    always_comb begin
        case (state)
            IDLE:    stall = memop;
            IND:     stall = 1'b1;
            ACCESS:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            addr_q           <= '0;
            sd_q             <= '0;
            write_q          <= 1'b0;
            byte_q           <= 1'b0;
            dmem_address     <= '0;
            dmem_wdata       <= '0;
            dmem_byte_enable <= 2'b00;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            mdr_out          <= '0;
            mar_out          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        addr_q       <= addr;
                        sd_q         <= store_data;
                        write_q      <= mem_write;
                        byte_q       <= mem_byte & ~mem_indirect;
                        dmem_address <= word_addr(addr);
                        if (mem_indirect) begin
                            state            <= IND;
                            dmem_read        <= 1'b1;
                            dmem_write       <= 1'b0;
                            dmem_byte_enable <= BE_WORD;
                        end else begin
                            state            <= ACCESS;
                            dmem_read        <= ~mem_write;
                            dmem_write       <= mem_write;
                            dmem_byte_enable <= mem_write ? align_be : BE_WORD;
                            dmem_wdata       <= align_wdata;
                        end
                    end
                end
                IND: begin
                    if (dmem_resp) begin
                        state            <= ACCESS;
                        addr_q           <= dmem_rdata;
                        dmem_address     <= word_addr(dmem_rdata);
                        dmem_read        <= ~write_q;
                        dmem_write       <= write_q;
                        dmem_byte_enable <= write_q ? align_be : BE_WORD;
                        dmem_wdata       <= align_wdata;
                    end
                end
                ACCESS: begin
                    if (dmem_resp) begin
                        state            <= DONE;
                        mar_out          <= addr_q;
                        if (!write_q) begin
                            mdr_out <= dmem_rdata;
                        end
                        dmem_read        <= 1'b0;
                        dmem_write       <= 1'b0;
                        dmem_byte_enable <= 2'b00;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random ops
// against a transaction-level memory/register model.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset_n;
    logic        valid_in;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte;
    logic        mem_indirect;
    logic [15:0] addr;
    logic [15:0] store_data;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic        dmem_read;
    logic        dmem_write;
    logic        stall;
    logic [15:0] mdr_out;
    logic [15:0] mar_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] mdr_m = 16'h0;
    logic [15:0] mar_m = 16'h0;

    mem_access_ctrl #(.WIDTH(16)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .valid_in         (valid_in),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_byte         (mem_byte),
        .mem_indirect     (mem_indirect),
        .addr             (addr),
        .store_data       (store_data),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .stall            (stall),
        .mdr_out          (mdr_out),
        .mar_out          (mar_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] memrd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 16'ha55a;
    endfunction

    // Runs one op from its IDLE cycle (called at a negedge) through DONE; returns at
    // the negedge of the following IDLE cycle. w0 = waits on pointer read, w1 = final.
    task automatic do_op(input bit wr, input bit byt, input bit ind,
                         input logic [15:0] a, input logic [15:0] sd,
                         input int w0, input int w1);
        logic [15:0] ea [2];
        bit          ewr [2];
        logic [1:0]  ebe [2];
        logic [15:0] ewd [2];
        logic [15:0] eff;
        logic [15:0] word;
        int          n;
        int          wk;
        n = 0;
        if (ind) begin
            ea[0]  = {a[15:1], 1'b0};
            ewr[0] = 1'b0;
            ebe[0] = 2'b11;
            ewd[0] = 16'h0;
            eff    = memrd(ea[0]);
            n      = 1;
        end else begin
            eff = a;
        end
        ea[n]  = {eff[15:1], 1'b0};
        ewr[n] = wr;
        ebe[n] = !wr ? 2'b11 : (byt ? (eff[0] ? 2'b10 : 2'b01) : 2'b11);
        ewd[n] = byt ? {sd[7:0], sd[7:0]} : sd;
        n++;

        valid_in     = 1'b1;
        mem_read     = !wr;
        mem_write    = wr;
        mem_byte     = byt;
        mem_indirect = ind;
        addr         = a;
        store_data   = sd;
        #1;
        chk("idle_stall", stall, 1'b1);
        chk("idle_noreq", {dmem_read, dmem_write}, 2'b00);
        @(posedge clk);
        @(negedge clk);

        for (int k = 0; k < n; k++) begin
            wk = (k == n - 1) ? w1 : w0;
            for (int w = 0; w <= wk; w++) begin
                chk("req_read", dmem_read, !ewr[k]);
                chk("req_write", dmem_write, ewr[k]);
                chk("req_addr", dmem_address, ea[k]);
                chk("req_be", dmem_byte_enable, ebe[k]);
                if (ewr[k]) chk("req_wdata", dmem_wdata, ewd[k]);
                chk("busy_stall", stall, 1'b1);
                // Inputs are scrambled while stalled; the controller must ignore them.
                mem_read     = $urandom_range(0, 1);
                mem_write    = $urandom_range(0, 1);
                mem_byte     = $urandom_range(0, 1);
                mem_indirect = $urandom_range(0, 1);
                addr         = 16'($urandom);
                store_data   = 16'($urandom);
                dmem_resp    = (w == wk);
                dmem_rdata   = (w == wk && !ewr[k]) ? memrd(ea[k]) : 16'($urandom);
                @(posedge clk);
                @(negedge clk);
            end
        end

        dmem_resp = 1'b0;
        valid_in  = 1'b0;
        if (wr) begin
            word = memrd(ea[n-1]);
            if (ebe[n-1][0]) word[7:0]  = sd[7:0];
            if (ebe[n-1][1]) word[15:8] = sd[7:0];
            mem[ea[n-1]] = word;
        end else begin
            mdr_m = memrd(ea[n-1]);
        end
        mar_m = eff;
        chk("done_stall", stall, 1'b0);
        chk("done_noreq", {dmem_read, dmem_write}, 2'b00);
        chk("done_mdr", mdr_out, mdr_m);
        chk("done_mar", mar_out, mar_m);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int kind;
        reset_n      = 1'b0;
        valid_in     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_byte     = 1'b0;
        mem_indirect = 1'b0;
        addr         = 16'h0;
        store_data   = 16'h0;
        dmem_resp    = 1'b0;
        dmem_rdata   = 16'h0;
        #1;
        chk("rst_req", {dmem_read, dmem_write}, 2'b00);
        chk("rst_be", dmem_byte_enable, 2'b00);
        chk("rst_addr", dmem_address, 16'h0);
        chk("rst_wdata", dmem_wdata, 16'h0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_mdr", mdr_out, 16'h0);
        chk("rst_mar", mar_out, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        mem[16'h6000] = 16'h7004;
        mem[16'h7004] = 16'h1234;
        mem[16'h5000] = 16'h7f80;

        do_op(1'b1, 1'b0, 1'b0, 16'h3002, 16'hbeef, 0, 2);  // STR, 2 waits
        do_op(1'b1, 1'b1, 1'b0, 16'h4001, 16'h12a5, 0, 0);  // STB high lane
        do_op(1'b0, 1'b1, 1'b0, 16'h5000, 16'h0000, 0, 0);  // LDB
        do_op(1'b0, 1'b0, 1'b1, 16'h6000, 16'h0000, 0, 0);  // LDI

        // STI interrupted by reset while in the pointer-read state
        valid_in     = 1'b1;
        mem_read     = 1'b0;
        mem_write    = 1'b1;
        mem_byte     = 1'b0;
        mem_indirect = 1'b1;
        addr         = 16'h6000;
        store_data   = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        chk("ind_read", dmem_read, 1'b1);
        valid_in = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_req", {dmem_read, dmem_write}, 2'b00);
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_mdr", mdr_out, 16'h0);
        chk("mid_rst_mar", mar_out, 16'h0);
        mdr_m = 16'h0;
        mar_m = 16'h0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Back-to-back STR then LDR, then a stray response in IDLE
        do_op(1'b1, 1'b0, 1'b0, 16'h2000, 16'hcafe, 0, 1);
        do_op(1'b0, 1'b0, 1'b0, 16'h2001, 16'h0000, 0, 0);
        dmem_resp  = 1'b1;
        dmem_rdata = 16'hffff;
        @(posedge clk);
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("stray_mdr", mdr_out, mdr_m);
        chk("stray_mar", mar_out, mar_m);
        chk("stray_req", {dmem_read, dmem_write}, 2'b00);
        chk("stray_stall", stall, 1'b0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 5);
            do_op(kind >= 3, (kind % 3) == 1, (kind % 3) == 2,
                  16'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
